// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Holds the FSM state encoding and the regfile shared-port owner codes.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    PAUSED = 2'b01,
    HALTED = 2'b10,
    STEP   = 2'b11
  } seq_state_t;

  localparam logic [1:0] PSEL_SCAN = 2'b00;
  localparam logic [1:0] PSEL_ID   = 2'b01;
  localparam logic [1:0] PSEL_WB   = 2'b10;

  // An advance reads operands; the following cycle writes back; otherwise the scan owns the port.
  function automatic logic [1:0] portOwner(input logic adv, input logic wb);
    if (adv)     return PSEL_ID;
    else if (wb) return PSEL_WB;
    else         return PSEL_SCAN;
  endfunction

endpackage

// File: rtl/pipe_sequencer_adv_divider.sv
// Free-running advance divider: DIV_W-bit counter with synchronous clear,
// count enable and an all-ones terminal-count flag.
module adv_divider #(
  parameter int DIV_W = 6
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [DIV_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + DIV_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tc_o = &count_q;

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: run/pause/breakpoint/single-step control of the pipeline advance strobe.
// Optional ADV pulse counter port ADV_CNT is built when PIPE_SEQ_ADV_CNT_EN is defined.
module pipe_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int DIV_W = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PAUSE,
  input  logic       STEP_DOWN,
  input  logic       BP_EN,
  input  logic [7:0] BP_ADDR,
  input  logic [7:0] PC,
  output logic       ADV,
  output logic       WB_WIN,
  output logic [1:0] PORT_SEL,
  output logic [3:0] SCAN_ADDR,
  output logic [1:0] STATE
`ifdef PIPE_SEQ_ADV_CNT_EN
  ,
  output logic [31:0] ADV_CNT
`endif
);

  seq_state_t state_q, state_d;
  logic       pend_q, pend_d;
  logic       wb_q;
  logic [3:0] scan_q, scan_d;
  logic       adv;
  logic       bpHit;
  logic       stepReq;
  logic       divClr, divEn, divTc;
  logic [1:0] portSel;

  adv_divider #(.DIV_W(DIV_W)) u_div (
    .CLK   (CLK),
    .RST   (RST),
    .clr_i (divClr),
    .en_i  (divEn),
    .tc_o  (divTc)
  );

  assign bpHit = BP_EN && (PC == BP_ADDR);

  // A step request is only taken once the writeback window has closed; a pulse
  // arriving inside the window is remembered in pend_q, and only one is kept.
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    adv     = 1'b0;
    stepReq = 1'b0;
    divClr  = 1'b0;
    divEn   = 1'b0;
    case (state_q)
      RUN: begin
        divEn = 1'b1;
        if (PAUSE) begin
          state_d = PAUSED;
          divClr  = 1'b1;
        end else if (divTc && bpHit) begin
          state_d = HALTED;
        end else if (divTc) begin
          adv = 1'b1;
        end
      end
      PAUSED, HALTED: begin
        divClr  = 1'b1;
        pend_d  = pend_q;
        stepReq = (STEP_DOWN || pend_q) && !wb_q;
        if (stepReq) begin
          state_d = STEP;
          pend_d  = 1'b0;
        end else begin
          if (STEP_DOWN && wb_q) pend_d = 1'b1;
          if (state_q == PAUSED && !PAUSE) state_d = RUN;
        end
      end
      STEP: begin
        adv     = 1'b1;
        divClr  = 1'b1;
        state_d = PAUSE ? PAUSED : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign portSel = portOwner(adv, wb_q);
  assign scan_d  = (portSel == PSEL_SCAN) ? scan_q + 4'd1 : scan_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      wb_q    <= 1'b0;
      scan_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wb_q    <= adv;
      scan_q  <= scan_d;
    end
  end

  assign ADV       = adv;
  assign WB_WIN    = wb_q;
  assign PORT_SEL  = portSel;
  assign SCAN_ADDR = scan_q;
  assign STATE     = state_q;

`ifdef PIPE_SEQ_ADV_CNT_EN
  logic [31:0] advCnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      advCnt_q <= 32'd0;
    else if (adv) advCnt_q <= advCnt_q + 32'd1;
  end

  assign ADV_CNT = advCnt_q;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed testbench for pipe_sequencer with DIV_W=2 (one advance every 4 cycles in RUN).
module tb_pipe_sequencer;
  import pipe_seq_pkg::*;

  logic       clk, rst, pause, stepDown, bpEn;
  logic [7:0] bpAddr, pc;
  logic       adv, wbWin;
  logic [1:0] portSel, state;
  logic [3:0] scanAddr;
`ifdef PIPE_SEQ_ADV_CNT_EN
  logic [31:0] advCnt;
`endif

  int vectorCount = 0;
  int missCount   = 0;
  int scanModel;
  int advPulses;
  logic expAdv, expWb;
  logic [1:0] expSel;

  pipe_sequencer #(.DIV_W(2)) dut (
    .CLK       (clk),
    .RST       (rst),
    .PAUSE     (pause),
    .STEP_DOWN (stepDown),
    .BP_EN     (bpEn),
    .BP_ADDR   (bpAddr),
    .PC        (pc),
    .ADV       (adv),
    .WB_WIN    (wbWin),
    .PORT_SEL  (portSel),
    .SCAN_ADDR (scanAddr),
    .STATE     (state)
`ifdef PIPE_SEQ_ADV_CNT_EN
    ,
    .ADV_CNT   (advCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Moves to the next cycle, drives inputs just after the edge and settles before sampling.
  task automatic applyStimulus(input logic pPause, input logic pStep, input logic pBpEn,
                               input logic [7:0] pBpAddr, input logic [7:0] pPc);
    @(posedge clk);
    #1;
    pause = pPause; stepDown = pStep; bpEn = pBpEn; bpAddr = pBpAddr; pc = pPc;
    #1;
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; stepDown = 1'b0; bpEn = 1'b0; bpAddr = 8'h00; pc = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstState", 32'(state), 32'(RUN));
    checkOutput("rstAdv", 32'(adv), 32'd0);
    checkOutput("rstWb", 32'(wbWin), 32'd0);
    checkOutput("rstSel", 32'(portSel), 32'(PSEL_SCAN));
    checkOutput("rstScan", 32'(scanAddr), 32'd0);
`ifdef PIPE_SEQ_ADV_CNT_EN
    checkOutput("rstCnt", advCnt, 32'd0);
`endif

    // Free run: ADV at cycles 3,7,11; WB_WIN one cycle later; scan only moves on free cycles.
    @(posedge clk); #1; rst = 1'b0; #1;
    scanModel = 0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      expAdv = (k % 4 == 3);
      expWb  = (k >= 4) && (k % 4 == 0);
      expSel = expAdv ? PSEL_ID : (expWb ? PSEL_WB : PSEL_SCAN);
      checkOutput("runAdv", 32'(adv), 32'(expAdv));
      checkOutput("runWb", 32'(wbWin), 32'(expWb));
      checkOutput("runSel", 32'(portSel), 32'(expSel));
      checkOutput("runScan", 32'(scanAddr), 32'(scanModel));
      if (expSel == PSEL_SCAN) scanModel++;
    end

    // Pause at terminal count, then a single step.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("pauseNoAdv", 32'(adv), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("pausedState", 32'(state), 32'(PAUSED));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("stepPulseAdv", 32'(adv), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("stepState", 32'(state), 32'(STEP));
    checkOutput("stepAdv", 32'(adv), 32'd1);
    checkOutput("stepSel", 32'(portSel), 32'(PSEL_ID));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("stepBackState", 32'(state), 32'(PAUSED));
    checkOutput("stepWb", 32'(wbWin), 32'd1);
    checkOutput("stepWbSel", 32'(portSel), 32'(PSEL_WB));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      checkOutput("pausedQuiet", 32'(adv), 32'd0);
    end

    // Step pulses during the writeback window: one pending step, served after the window.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("pendFirstAdv", 32'(adv), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("pendInWb", 32'(wbWin), 32'd1);
    checkOutput("pendInWbAdv", 32'(adv), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("pendGapAdv", 32'(adv), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("pendServedAdv", 32'(adv), 32'd1);
    checkOutput("pendServedState", 32'(state), 32'(STEP));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("pendWb", 32'(wbWin), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      checkOutput("pendDropped", 32'(adv), 32'd0);
    end

    // Breakpoint at PC 05: halt at terminal count, PAUSE ignored, STEP_DOWN resumes.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("unpauseState", 32'(state), 32'(PAUSED));
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("resumeState", 32'(state), 32'(RUN));
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("bpNoAdv", 32'(adv), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("bpHalted", 32'(state), 32'(HALTED));
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("haltPause", 32'(state), 32'(HALTED));
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("haltUnpause", 32'(state), 32'(HALTED));
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h05, 8'h05);
    checkOutput("haltStepPulse", 32'(adv), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h05, 8'h05);
    checkOutput("haltStepAdv", 32'(adv), 32'd1);
    checkOutput("haltStepState", 32'(state), 32'(STEP));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h05, 8'h05);
    checkOutput("haltToRun", 32'(state), 32'(RUN));
    checkOutput("haltToRunWb", 32'(wbWin), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h05, 8'h05);
    checkOutput("afterStepDiv1", 32'(adv), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h05, 8'h05);
    checkOutput("afterStepDiv2", 32'(adv), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h05, 8'h05);
    checkOutput("afterStepDiv3", 32'(adv), 32'd1);

    // PAUSE and breakpoint at the same terminal count: PAUSED wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h05, 8'h05);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h05);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("bothNoAdv", 32'(adv), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("bothPaused", 32'(state), 32'(PAUSED));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h05, 8'h05);

    // Reset asserted while in STEP kills the strobe at once.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h05);
    checkOutput("preRstStep", 32'(state), 32'(STEP));
    rst = 1'b1;
    #1;
    checkOutput("rstStepAdv", 32'(adv), 32'd0);
    checkOutput("rstStepState", 32'(state), 32'(RUN));
    @(posedge clk); #1;
    checkOutput("rstStepWb", 32'(wbWin), 32'd0);
    rst = 1'b0; pause = 1'b0; bpEn = 1'b0;
    #1;
    checkOutput("postRstScan", 32'(scanAddr), 32'd0);
    checkOutput("postRstState", 32'(state), 32'(RUN));

    // Ten advances in free run, then reset clears the counter.
    advPulses = 0;
    for (int k = 1; k <= 41; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (adv === 1'b1) advPulses++;
    end
    checkOutput("advPulses", 32'(advPulses), 32'd10);
`ifdef PIPE_SEQ_ADV_CNT_EN
    checkOutput("advCnt10", advCnt, 32'd10);
    rst = 1'b1;
    #1;
    checkOutput("advCntRst", advCnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 6, divider width; one advance per 2^DIV_W CLK cycles in RUN; legal range 2..16.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PAUSE  input  1  run/pause switch level, already synchronised to CLK.
REQ-005 SHALL have port STEP_DOWN  input  1  one-CLK pulse from step-button debouncer.
REQ-006 SHALL have port BP_EN  input  1  breakpoint enable.
REQ-007 SHALL have port BP_ADDR  input  8  breakpoint instruction address.
REQ-008 SHALL have port PC  input  8  current fetch address.
REQ-009 SHALL have port ADV  output  1  one-CLK pipeline-advance strobe.
REQ-010 SHALL have port WB_WIN  output  1  regfile writeback window, the cycle after ADV.
REQ-011 SHALL have port PORT_SEL  output  2  regfile shared-port owner: 00 scan, 01 ID read, 10 WB write.
REQ-012 SHALL have port SCAN_ADDR  output  4  debug scan register address.
REQ-013 SHALL have port STATE  output  2  FSM state: 00 RUN, 01 PAUSED, 10 HALTED, 11 STEP.

Function
REQ-014 SHALL implement an FSM with states RUN, PAUSED, HALTED, STEP.
REQ-015 In RUN: the divider increments each cycle, and ADV=1 for exactly one cycle when the divider equals all-ones.
REQ-016 In RUN with PAUSE=1: next state SHALL be PAUSED, with the divider cleared to 0 and no ADV that cycle.
REQ-017 In RUN at the all-ones divider cycle with BP_EN=1 and PC==BP_ADDR: next state SHALL be HALTED, ADV SHALL be suppressed, and the divider wraps to 0.
REQ-018 When PAUSE=1 and a breakpoint match occur in the same cycle, PAUSED SHALL win.
REQ-019 In PAUSED or HALTED: a STEP_DOWN pulse SHALL move the FSM to STEP, and ADV=1 in the STEP cycle.
REQ-020 From STEP: the next state SHALL be PAUSED if PAUSE=1, else RUN with the divider at 0.
REQ-021 In PAUSED with PAUSE=0: the next state SHALL be RUN; HALTED SHALL ignore PAUSE and leave only via STEP.
REQ-022 STEP_DOWN in RUN or STEP SHALL be ignored.
REQ-023 STEP_DOWN arriving while ADV or WB_WIN=1 SHALL be latched as pending and served at the first cycle where both are 0; only one pending step is held, and further pulses are dropped.
REQ-024 WB_WIN SHALL equal ADV delayed one CLK, and consecutive ADVs SHALL be at least 3 cycles apart.
REQ-025 PORT_SEL SHALL be 01 when ADV=1, 10 when WB_WIN=1, else 00.
REQ-026 SCAN_ADDR SHALL increment modulo 16 in each cycle where PORT_SEL==00 and hold otherwise.

Reset
REQ-027 While RST=1: STATE=RUN, divider=0, ADV=0, WB_WIN=0, PORT_SEL=00, SCAN_ADDR=0, pending step cleared, ADV_CNT=0.
REQ-028 RST mid-operation (including in STEP or during WB_WIN) SHALL abort immediately with no further ADV or WB_WIN pulse.

Configuration
REQ-029 Macro PIPE_SEQ_ADV_CNT_EN: when defined, port ADV_CNT output 32 SHALL count ADV pulses, wrapping at 2^32, reset to 0.
REQ-030 Without PIPE_SEQ_ADV_CNT_EN, ADV_CNT and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package pipe_seq_pkg SHALL hold the state enum (RUN, PAUSED, HALTED, STEP) and the PORT_SEL constants (PSEL_SCAN, PSEL_ID, PSEL_WB).
REQ-032 The divider SHALL be a sub-module adv_divider (DIV_W-bit counter, clear input, terminal-count output).

Verification
REQ-033 DIV_W=2, PAUSE=0 after reset -> ADV at cycles 3, 7, 11; WB_WIN at 4, 8, 12; PORT_SEL 01/10 at those cycles; SCAN_ADDR advances only in other cycles.
REQ-034 PAUSE=1, STEP_DOWN pulse -> exactly one ADV the next cycle, STATE 01->11->01, then no further ADV.
REQ-035 BP_EN=1, BP_ADDR=8'h05, PC=8'h05 at terminal count -> no ADV, STATE=HALTED; STEP_DOWN -> one ADV, then RUN with PAUSE=0.
REQ-036 STEP_DOWN in the same cycle as WB_WIN in PAUSED -> ADV the following cycle; a second pulse in the same window is dropped (only one ADV).
REQ-037 PAUSE=1 and breakpoint match in the same cycle -> STATE=PAUSED; RST asserted in STEP -> ADV=0 that cycle, STATE=RUN.
REQ-038 PIPE_SEQ_ADV_CNT_EN defined, 10 advances -> ADV_CNT=10; after RST -> 0.
